ripple_adder_scheduler: RTL and testbench

// - Shares one 4-bit ripple-carry adder slice between two requesters (req0, req1).
// - Adds WIDTH-bit operands word-serially, 4 bits per cycle, LSB slice first.
// - Carry is registered between slices.
// - Round-robin arbiter plus sequencer FSM; results return on a single valid/ready response port tagged with requester id.

---
 rtl/ripple_adder_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ripple_adder_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_adder_scheduler.sv
// Word-serial adder: two requesters share one 4-bit ripple slice, round-robin arbitrated.
// Optional macro RSP_OVF_EN adds the registered signed-overflow output rsp_ovf.
module ripple_adder_scheduler #(
   parameter  int WIDTH  = 16,
   localparam int NCHUNK = WIDTH / 4,
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
`ifdef RSP_OVF_EN
   output logic             rsp_id,
   output logic             rsp_ovf
`else
   output logic             rsp_id
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_r;
   logic             rr_ptr_r;
   logic             id_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] rsp_sum_r;
   logic             rsp_cout_r;
   logic             rsp_id_r;
   logic             rsp_valid_r;

   logic             any_valid_s;
   logic             grant_s;
   logic [3:0]       a_sl_s;
   logic [3:0]       b_sl_s;
   logic [4:0]       slice_s;
   logic [WIDTH-1:0] next_sum_s;
   logic             last_s;

`ifdef RSP_OVF_EN
   logic             rsp_ovf_r;

   function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
   endfunction

   assign rsp_ovf = rsp_ovf_r;
`endif

   assign rsp_valid = rsp_valid_r;
   assign rsp_sum   = rsp_sum_r;
   assign rsp_cout  = rsp_cout_r;
   assign rsp_id    = rsp_id_r;

   // Arbitration: a lone requester wins, a tie goes to rr_ptr; ready only in IDLE.
   always_comb begin
      any_valid_s = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_s = rr_ptr_r;
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
      if (state_r == IDLE && any_valid_s) begin
         req0_ready = ~grant_s;
         req1_ready = grant_s;
      end else begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end
   end

   // Shared 4-bit slice operating on chunk cnt_r.
   always_comb begin
      a_sl_s     = a_r[{cnt_r, 2'b00} +: 4];
      b_sl_s     = b_r[{cnt_r, 2'b00} +: 4];
      slice_s    = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {4'd0, carry_r};
      next_sum_s = sum_r;
      next_sum_s[{cnt_r, 2'b00} +: 4] = slice_s[3:0];
      last_s     = (cnt_r == CNT_W'(NCHUNK - 1));
   end

   // Sequencer: accept, ripple one slice per cycle, then hold the result until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         carry_r     <= 1'b0;
         rr_ptr_r    <= 1'b0;
         id_r        <= 1'b0;
         a_r         <= '0;
         b_r         <= '0;
         sum_r       <= '0;
         rsp_sum_r   <= '0;
         rsp_cout_r  <= 1'b0;
         rsp_id_r    <= 1'b0;
         rsp_valid_r <= 1'b0;
`ifdef RSP_OVF_EN
         rsp_ovf_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (any_valid_s) begin
                  a_r     <= grant_s ? req1_a   : req0_a;
                  b_r     <= grant_s ? req1_b   : req0_b;
                  carry_r <= grant_s ? req1_cin : req0_cin;
                  id_r    <= grant_s;
                  cnt_r   <= '0;
                  sum_r   <= '0;
                  state_r <= ADD;
               end
            end
            ADD: begin
               sum_r   <= next_sum_s;
               carry_r <= slice_s[4];
               cnt_r   <= cnt_r + CNT_W'(1);
               if (last_s) begin
                  rsp_sum_r   <= next_sum_s;
                  rsp_cout_r  <= slice_s[4];
                  rsp_id_r    <= id_r;
                  rsp_valid_r <= 1'b1;
`ifdef RSP_OVF_EN
                  rsp_ovf_r   <= ovf_f(a_r[WIDTH-1], b_r[WIDTH-1], next_sum_s[WIDTH-1]);
`endif
                  state_r     <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  rr_ptr_r    <= ~rsp_id_r;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ripple_adder_scheduler.sv
// Directed self-checking bench for ripple_adder_scheduler (WIDTH=16).
// Define RSP_OVF_EN on both RTL and bench to exercise the overflow output.
module tb_ripple_adder_scheduler;
   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready, req0_cin;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready, req1_cin;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_cout, rsp_id;
   logic [WIDTH-1:0] rsp_sum;
`ifdef RSP_OVF_EN
   logic             rsp_ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   ripple_adder_scheduler #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
`ifdef RSP_OVF_EN
      .rsp_id(rsp_id), .rsp_ovf(rsp_ovf)
`else
      .rsp_id(rsp_id)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick;
         lat++;
      end
   endtask

   // One operation from requester id with rsp_ready high; checks latency and result.
   task automatic do_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
      int lat;
      if (id) begin
         req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
      end
      #1;
      check("op_ready", id ? req1_ready : req0_ready, 1'b1);
      check("op_other_ready", id ? req0_ready : req1_ready, 1'b0);
      tick;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~a; req1_a = ~a; req0_b = ~b; req1_b = ~b;
      #1;
      check("add_ready", {req0_ready, req1_ready}, 2'b00);
      wait_rsp(lat);
      // accept edge plus four slice edges: valid after the fifth edge overall
      check("op_latency", lat, 4);
      check("op_sum", rsp_sum, es);
      check("op_cout", rsp_cout, ec);
      check("op_id", rsp_id, id);
`ifdef RSP_OVF_EN
      check("op_ovf", rsp_ovf, eo);
`else
      if (eo) n_tests = n_tests + 0;
`endif
      tick;
      check("op_taken", rsp_valid, 1'b0);
   endtask

   logic [WIDTH-1:0] ta [2][4];
   logic [WIDTH-1:0] tb [2][4];
   logic             tc [2][4];
   logic [WIDTH:0]   te [2][4];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen, lat, last_cyc, w;
      int idx [2];
      logic g;
      logic [WIDTH-1:0] hold_sum;

      ta[0][0] = 16'h0001; tb[0][0] = 16'h0002; tc[0][0] = 1'b0; te[0][0] = 17'h0_0003;
      ta[0][1] = 16'h00FF; tb[0][1] = 16'h0001; tc[0][1] = 1'b0; te[0][1] = 17'h0_0100;
      ta[0][2] = 16'h0FFF; tb[0][2] = 16'h0001; tc[0][2] = 1'b1; te[0][2] = 17'h0_1001;
      ta[0][3] = 16'h8000; tb[0][3] = 16'h8000; tc[0][3] = 1'b0; te[0][3] = 17'h1_0000;
      ta[1][0] = 16'h1111; tb[1][0] = 16'h2222; tc[1][0] = 1'b0; te[1][0] = 17'h0_3333;
      ta[1][1] = 16'hFFFF; tb[1][1] = 16'h0001; tc[1][1] = 1'b0; te[1][1] = 17'h1_0000;
      ta[1][2] = 16'hABCD; tb[1][2] = 16'h1111; tc[1][2] = 1'b1; te[1][2] = 17'h0_BCDF;
      ta[1][3] = 16'hF0F0; tb[1][3] = 16'h0F0F; tc[1][3] = 1'b1; te[1][3] = 17'h1_0000;

      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      tick; tick;
      rst = 1'b0;
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_sum", rsp_sum, 16'h0000);
      check("rst_cout_id", {rsp_cout, rsp_id}, 2'b00);
      check("rst_ready", {req0_ready, req1_ready}, 2'b00);
`ifdef RSP_OVF_EN
      check("rst_ovf", rsp_ovf, 1'b0);
`endif
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (rsp_valid) seen++;
      end
      check("idle_no_rsp", seen, 0);

      // Reset in the middle of ADD abandons the operation.
      req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0; req0_valid = 1'b1;
      tick;
      req0_valid = 1'b0;
      tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("midrst_valid", rsp_valid, 1'b0);
      req1_valid = 1'b1;
      #1;
      check("midrst_idle", req1_ready, 1'b1);
      req1_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (rsp_valid) seen++;
      end
      check("midrst_no_rsp", seen, 0);

      do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      do_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op(1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Round robin with both requesters continuously valid.
      idx[0] = 0; idx[1] = 0; last_cyc = 0;
      req0_a = ta[0][0]; req0_b = tb[0][0]; req0_cin = tc[0][0]; req0_valid = 1'b1;
      req1_a = ta[1][0]; req1_b = tb[1][0]; req1_cin = tc[1][0]; req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         w = 0;
         while (!(req0_ready || req1_ready) && w < 20) begin
            tick;
            w++;
         end
         check("rr_wait", w, 0);
         check("rr_onehot", req0_ready & req1_ready, 1'b0);
         g = req1_ready;
         check("rr_grant", g, k[0]);
         if (k > 0) check("rr_period", cyc - last_cyc, 6);
         last_cyc = cyc;
         tick;
         idx[g] = idx[g] + 1;
         if (g) begin
            if (idx[1] < 4) begin
               req1_a = ta[1][idx[1]]; req1_b = tb[1][idx[1]]; req1_cin = tc[1][idx[1]];
            end else begin
               req1_valid = 1'b0;
            end
         end else begin
            if (idx[0] < 4) begin
               req0_a = ta[0][idx[0]]; req0_b = tb[0][idx[0]]; req0_cin = tc[0][idx[0]];
            end else begin
               req0_valid = 1'b0;
            end
         end
         wait_rsp(lat);
         check("rr_latency", lat, 4);
         check("rr_id", rsp_id, g);
         check("rr_result", {rsp_cout, rsp_sum}, te[g][idx[g] - 1]);
         tick;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Backpressure: result held while rsp_ready is low, requesters locked out.
      rsp_ready = 1'b0;
      req0_a = 16'h0F0F; req0_b = 16'h0101; req0_cin = 1'b1; req0_valid = 1'b1;
      #1;
      check("bp_accept", req0_ready, 1'b1);
      tick;
      req0_valid = 1'b0; req1_valid = 1'b1;
      wait_rsp(lat);
      check("bp_latency", lat, 4);
      hold_sum = rsp_sum;
      check("bp_sum", hold_sum, 16'h1011);
      for (int i = 0; i < 10; i++) begin
         tick;
         check("bp_valid", rsp_valid, 1'b1);
         check("bp_stable", {rsp_cout, rsp_id, rsp_sum}, {2'b00, 16'h1011});
         check("bp_ready", {req0_ready, req1_ready}, 2'b00);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_hs_ready", req1_ready, 1'b0);
      tick;
      check("bp_released", rsp_valid, 1'b0);
      check("bp_idle_grant", req1_ready, 1'b1);
      req1_valid = 1'b0;
      tick;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
